// File: rtl/sysctrl_multi_if.sv
// sysctrl_multi_if: MCU byte command channel (start/strobe framed bytes in, response byte out)
interface sysctrl_multi_if;
    logic data_in_strobe;
    logic data_in_start;
    logic [7:0] data_in;
    logic [7:0] data_out;
    modport master(output data_in_strobe, data_in_start, data_in, input data_out);
    modport slave(input data_in_strobe, data_in_start, data_in, output data_out);
endinterface

// File: rtl/sysctrl_multi.sv
// sysctrl_multi: MCU system-control slave driving core reset, config slots, LEDs, colour and MCU IRQ
// Menu ROM contents arrive as the MENU_ROM parameter (byte k at [8*k+:8]) so the ROM needs no load step.
module sysctrl_multi #(
    parameter int NUM_BUTTONS = 2,
    parameter int NUM_LEDS = 2,
    parameter int NUM_CFG = 4,
    parameter logic [8*NUM_CFG-1:0] CFG_IDS = "RYAB",
    parameter logic [8*NUM_CFG-1:0] CFG_DEFAULTS = '0,
    parameter int RESET_TIMEOUT = 86_000_000,
    parameter logic [7:0] CORE_ID = 8'h00,
    parameter int MENU_AW = 10,
    parameter logic [8*(2**MENU_AW)-1:0] MENU_ROM = '0
) (
    input logic clk,
    input logic reset,
    sysctrl_multi_if.slave bus,
    output logic int_out_n,
    input logic [7:0] int_in,
    output logic [7:0] int_ack,
    input logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_LEDS-1:0] leds,
    output logic [23:0] color,
    output logic system_reset,
    output logic [8*NUM_CFG-1:0] cfg_values
);
    localparam logic [7:0] ID_R = "R";
    logic [NUM_BUTTONS-1:0] btn_s1, btn_s2, btn_chg, btn_diff;
    logic [NUM_CFG-1:0] hit, first;
    logic [31:0] timeout;
    logic [7:0] command, id, rev, slot_val;
    logic [3:0] state;
    logic [MENU_AW-1:0] menu_addr;
    logic coldboot, sys_int;
    logic unused;
    assign unused = int_in[0];
    assign int_out_n = !(sys_int | (|int_in[7:1]));
    assign btn_diff = btn_s1 ^ btn_s2;
    assign rev = {<<{bus.data_in}};
    // Synchroniser keeps sampling through reset so held buttons never look like a change afterwards
    always_ff @(posedge clk) begin
        btn_s1 <= buttons;
        btn_s2 <= btn_s1;
    end
    always_comb begin
        hit = '0;
        slot_val = '0;
        for (int i = 0; i < NUM_CFG; i++) hit[i] = CFG_IDS[8*i+:8] == id;
        first = hit & (~hit + NUM_CFG'(1));
        for (int i = 0; i < NUM_CFG; i++) slot_val = slot_val | (first[i] ? cfg_values[8*i+:8] : 8'h00);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            leds <= '0;
            color <= '0;
            bus.data_out <= '0;
            int_ack <= '0;
            system_reset <= 1'b1;
            timeout <= 32'(RESET_TIMEOUT);
            cfg_values <= CFG_DEFAULTS;
            coldboot <= 1'b1;
            sys_int <= 1'b1;
            btn_chg <= '0;
            state <= '0;
            command <= 8'hFF;
            id <= '0;
            menu_addr <= '0;
        end else begin
            btn_chg <= btn_chg | btn_diff;
            sys_int <= (|btn_diff) | (sys_int & !int_ack[0]);
            int_ack <= '0;
            if (|timeout) timeout <= timeout - 32'd1;
            if (timeout == 32'd1) begin
                system_reset <= 1'b0;
                color <= 24'h000202;
            end
            if (bus.data_in_strobe && bus.data_in_start) begin
                command <= bus.data_in;
                state <= '0;
                menu_addr <= '0;
                bus.data_out <= '0;
            end else if (bus.data_in_strobe) begin
                if (state != 4'hF) state <= state + 4'd1;
                case (command)
                    8'd0: if (state < 4'd3) bus.data_out <= state == 4'd0 ? 8'h5C : state == 4'd1 ? 8'h42 : CORE_ID;
                    8'd1: if (state == 4'd0) leds <= bus.data_in[NUM_LEDS-1:0];
                    8'd2: begin
                        if (state == 4'd0) color[15:8] <= rev;
                        if (state == 4'd1) color[7:0] <= rev;
                        if (state == 4'd2) color[23:16] <= rev;
                    end
                    8'd3: begin
                        bus.data_out <= {4'(btn_chg), 4'(btn_s2)};
                        btn_chg <= btn_diff;
                    end
                    8'd4: begin
                        if (state == 4'd0) id <= bus.data_in;
                        if (state == 4'd1 && id == ID_R) begin
                            system_reset <= bus.data_in[0];
                            timeout <= '0;
                        end else if (state == 4'd1) begin
                            for (int i = 0; i < NUM_CFG; i++) if (first[i]) cfg_values[8*i+:8] <= bus.data_in;
                        end
                    end
                    8'd5: begin
                        if (state == 4'd0) int_ack <= bus.data_in;
                        bus.data_out <= {int_in[7:1], sys_int};
                    end
                    8'd6: begin
                        bus.data_out <= {5'b0, |btn_chg, 1'b0, coldboot};
                        if (state == 4'd0) coldboot <= 1'b0;
                    end
                    8'd8: begin
                        bus.data_out <= MENU_ROM[8*menu_addr+:8];
                        menu_addr <= menu_addr + MENU_AW'(1);
                    end
                    8'd9: begin
                        if (state == 4'd0) id <= bus.data_in;
                        else bus.data_out <= id == ID_R ? {7'b0, system_reset} : slot_val;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sysctrl_multi.sv
// tb_sysctrl_multi: randomized scenario bench for sysctrl_multi against a slot/flag-level reference model
module tb_sysctrl_multi;
    function automatic logic [127:0] make_rom();
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k+:8] = 8'(k * 29 + 7);
        return r;
    endfunction
    localparam logic [127:0] ROM = make_rom();
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] int_in = '0;
    logic [7:0] int_ack;
    logic int_out_n;
    logic [1:0] buttons = '0;
    logic [1:0] leds;
    logic [23:0] color;
    logic system_reset;
    logic [31:0] cfg_values;
    int vectors = 0;
    int errors = 0;
    logic [7:0] cfg_m [4];
    logic [7:0] ids [4] = '{"B", "A", "Y", "R"};
    logic [7:0] pool [6] = '{"B", "A", "Y", "R", "Z", "q"};
    logic sysrst_m, coldboot_m, sysint_m;
    logic [1:0] leds_m, chg_m, btn_m;
    logic [23:0] color_m;
    sysctrl_multi_if bus();
    always #5 clk = ~clk;
    sysctrl_multi #(
        .NUM_BUTTONS(2), .NUM_LEDS(2), .NUM_CFG(4), .CFG_IDS("RYAB"), .CFG_DEFAULTS(32'h11223344),
        .RESET_TIMEOUT(100), .CORE_ID(8'hA7), .MENU_AW(4), .MENU_ROM(ROM)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .int_out_n(int_out_n), .int_in(int_in), .int_ack(int_ack),
        .buttons(buttons), .leds(leds), .color(color), .system_reset(system_reset), .cfg_values(cfg_values)
    );
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction
    function automatic logic [7:0] cfg_read(input logic [7:0] id);
        if (id == "R") return {7'b0, sysrst_m};
        for (int i = 0; i < 4; i++) if (ids[i] == id) return cfg_m[i];
        return 8'h00;
    endfunction
    function automatic logic [31:0] cfg_vec();
        return {cfg_m[3], cfg_m[2], cfg_m[1], cfg_m[0]};
    endfunction
    task automatic idle(input int n);
        repeat (n) begin
            bus.data_in_strobe = 1'b0;
            bus.data_in_start = 1'($urandom);
            bus.data_in = 8'($urandom);
            @(negedge clk);
        end
    endtask
    task automatic send(input logic s, input logic [7:0] d);
        bus.data_in_strobe = 1'b1;
        bus.data_in_start = s;
        bus.data_in = d;
        @(negedge clk);
        bus.data_in_strobe = 1'b0;
    endtask
    task automatic do_reset();
        bus.data_in_strobe = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cfg_m = '{8'h44, 8'h33, 8'h22, 8'h11};
        sysrst_m = 1'b1;
        coldboot_m = 1'b1;
        sysint_m = 1'b1;
        leds_m = '0;
        chg_m = '0;
        color_m = '0;
    endtask
    task automatic cfg_write(input logic [7:0] id, input logic [7:0] v);
        send(1'b1, 8'd4);
        send(1'b0, id);
        idle($urandom_range(0, 2));
        send(1'b0, v);
        send(1'b0, ~v);
        if (id == "R") sysrst_m = v[0];
        else
            for (int i = 0; i < 4; i++)
                if (ids[i] == id) begin
                    cfg_m[i] = v;
                    break;
                end
    endtask
    task automatic test_reset();
        do_reset();
        vectors++; if (leds !== 2'b00) begin errors++; $display("FAIL reset_leds: got %h want 0", leds); end
        vectors++; if (color !== 24'h0) begin errors++; $display("FAIL reset_color: got %h want 0", color); end
        vectors++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
        vectors++; if (int_ack !== 8'h00) begin errors++; $display("FAIL reset_int_ack: got %h want 0", int_ack); end
        vectors++; if (system_reset !== 1'b1) begin errors++; $display("FAIL reset_system_reset: got %b want 1", system_reset); end
        vectors++; if (cfg_values !== cfg_vec()) begin errors++; $display("FAIL reset_cfg: got %h want %h", cfg_values, cfg_vec()); end
        vectors++; if (int_out_n !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", int_out_n); end
    endtask
    task automatic test_timeout();
        idle(99);
        vectors++; if (system_reset !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b want 1", system_reset); end
        vectors++; if (color !== 24'h0) begin errors++; $display("FAIL timeout_early_color: got %h want 0", color); end
        idle(1);
        vectors++; if (system_reset !== 1'b0) begin errors++; $display("FAIL timeout_release: got %b want 0", system_reset); end
        vectors++; if (color !== 24'h000202) begin errors++; $display("FAIL timeout_color: got %h want 000202", color); end
    endtask
    task automatic test_reset_hold();
        do_reset();
        idle(7);
        cfg_write("R", 8'h00);
        vectors++; if (system_reset !== sysrst_m) begin errors++; $display("FAIL hold_release: got %b want %b", system_reset, sysrst_m); end
        idle(120);
        vectors++; if (system_reset !== 1'b0) begin errors++; $display("FAIL hold_no_timeout: got %b want 0", system_reset); end
        vectors++; if (color !== 24'h0) begin errors++; $display("FAIL hold_color: got %h want 0", color); end
        cfg_write("R", 8'h01);
        vectors++; if (system_reset !== 1'b1) begin errors++; $display("FAIL hold_reassert: got %b want 1", system_reset); end
        send(1'b1, 8'd9);
        send(1'b0, "R");
        send(1'b0, 8'($urandom));
        vectors++; if (bus.data_out !== 8'h01) begin errors++; $display("FAIL hold_readback: got %h want 01", bus.data_out); end
        cfg_write("R", 8'hFE);
        vectors++; if (system_reset !== 1'b0) begin errors++; $display("FAIL hold_release2: got %b want 0", system_reset); end
    endtask
    task automatic test_cmd0();
        logic [7:0] exp [3] = '{8'h5C, 8'h42, 8'hA7};
        send(1'b1, 8'd0);
        vectors++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL cmd0_start: got %h want 00", bus.data_out); end
        for (int k = 0; k < 3; k++) begin
            idle($urandom_range(0, 2));
            send(1'b0, 8'($urandom));
            vectors++; if (bus.data_out !== exp[k]) begin errors++; $display("FAIL cmd0_byte%0d: got %h want %h", k, bus.data_out, exp[k]); end
        end
    endtask
    task automatic test_status();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) send(1'b1, 8'd6);
            send(1'b0, 8'($urandom));
            vectors++; if (bus.data_out !== {5'b0, |chg_m, 1'b0, coldboot_m}) begin errors++; $display("FAIL status_%0d: got %h want %h", k, bus.data_out, {5'b0, |chg_m, 1'b0, coldboot_m}); end
            coldboot_m = 1'b0;
        end
    endtask
    task automatic test_leds_color();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] l, c0, c1, c2;
            l = 8'($urandom); c0 = 8'($urandom); c1 = 8'($urandom); c2 = 8'($urandom);
            send(1'b1, 8'd1);
            send(1'b0, l);
            send(1'b0, ~l);
            leds_m = l[1:0];
            send(1'b1, 8'd2);
            send(1'b0, c0);
            idle($urandom_range(0, 2));
            send(1'b0, c1);
            send(1'b0, c2);
            send(1'b0, 8'($urandom));
            color_m = {rev8(c2), rev8(c0), rev8(c1)};
            vectors++; if (leds !== leds_m) begin errors++; $display("FAIL leds_%0d: got %h want %h", n, leds, leds_m); end
            vectors++; if (color !== color_m) begin errors++; $display("FAIL color_%0d: got %h want %h", n, color, color_m); end
        end
    endtask
    task automatic test_cfg();
        cfg_write("Y", 8'h02);
        vectors++; if (cfg_values[23:16] !== 8'h02) begin errors++; $display("FAIL cfg_y_slot: got %h want 02", cfg_values[23:16]); end
        for (int n = 0; n < 24; n++) begin
            logic [7:0] id, rid;
            if (n > 0) begin
                id = pool[$urandom_range(0, 5)];
                cfg_write(id, 8'($urandom));
            end
            vectors++; if (cfg_values !== cfg_vec()) begin errors++; $display("FAIL cfg_vec_%0d: got %h want %h", n, cfg_values, cfg_vec()); end
            vectors++; if (system_reset !== sysrst_m) begin errors++; $display("FAIL cfg_sysrst_%0d: got %b want %b", n, system_reset, sysrst_m); end
            rid = n == 0 ? 8'("Y") : n == 1 ? 8'("Z") : pool[$urandom_range(0, 5)];
            send(1'b1, 8'd9);
            send(1'b0, rid);
            send(1'b0, 8'($urandom));
            vectors++; if (bus.data_out !== cfg_read(rid)) begin errors++; $display("FAIL cfg_read_%0d id %h: got %h want %h", n, rid, bus.data_out, cfg_read(rid)); end
        end
    endtask
    task automatic test_buttons();
        send(1'b1, 8'd5);
        send(1'b0, 8'h01);
        idle(1);
        sysint_m = 1'b0;
        vectors++; if (int_out_n !== 1'b1) begin errors++; $display("FAIL btn_ack_clear: got %b want 1", int_out_n); end
        btn_m = 2'b10;
        buttons = btn_m;
        idle(4);
        chg_m = 2'b10;
        sysint_m = 1'b1;
        vectors++; if (int_out_n !== 1'b0) begin errors++; $display("FAIL btn_irq: got %b want 0", int_out_n); end
        send(1'b1, 8'd3);
        send(1'b0, 8'($urandom));
        vectors++; if (bus.data_out !== 8'h22) begin errors++; $display("FAIL btn_read1: got %h want 22", bus.data_out); end
        chg_m = '0;
        send(1'b0, 8'($urandom));
        vectors++; if (bus.data_out !== 8'h02) begin errors++; $display("FAIL btn_read2: got %h want 02", bus.data_out); end
        for (int n = 0; n < 6; n++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            btn_m = btn_m ^ m;
            buttons = btn_m;
            idle(4);
            chg_m = chg_m | m;
            sysint_m = 1'b1;
            send(1'b1, 8'd6);
            send(1'b0, 8'($urandom));
            vectors++; if (bus.data_out !== {5'b0, |chg_m, 1'b0, coldboot_m}) begin errors++; $display("FAIL btn_status_%0d: got %h want %h", n, bus.data_out, {5'b0, |chg_m, 1'b0, coldboot_m}); end
            if ($urandom_range(0, 1) == 1) begin
                send(1'b1, 8'd3);
                send(1'b0, 8'($urandom));
                vectors++; if (bus.data_out !== {2'b0, chg_m, 2'b0, btn_m}) begin errors++; $display("FAIL btn_rd_%0d: got %h want %h", n, bus.data_out, {2'b0, chg_m, 2'b0, btn_m}); end
                chg_m = '0;
            end
            vectors++; if (int_out_n !== 1'b0) begin errors++; $display("FAIL btn_irq_%0d: got %b want 0", n, int_out_n); end
        end
        send(1'b1, 8'd5);
        send(1'b0, 8'h01);
        idle(1);
        sysint_m = 1'b0;
        vectors++; if (int_out_n !== 1'b1) begin errors++; $display("FAIL btn_final_ack: got %b want 1", int_out_n); end
    endtask
    task automatic test_ack_collision();
        send(1'b1, 8'd5);
        btn_m = btn_m ^ 2'b01;
        buttons = btn_m;
        send(1'b0, 8'h01);
        vectors++; if (int_ack !== 8'h01) begin errors++; $display("FAIL coll_ack: got %h want 01", int_ack); end
        idle(1);
        vectors++; if (int_ack !== 8'h00) begin errors++; $display("FAIL coll_ack_pulse: got %h want 00", int_ack); end
        vectors++; if (int_out_n !== 1'b0) begin errors++; $display("FAIL coll_irq: got %b want 0", int_out_n); end
        idle(3);
        chg_m = chg_m | 2'b01;
        sysint_m = 1'b1;
        vectors++; if (int_out_n !== 1'b0) begin errors++; $display("FAIL coll_irq_hold: got %b want 0", int_out_n); end
    endtask
    task automatic test_int_in();
        for (int n = 0; n < 8; n++) begin
            logic [7:0] a;
            int_in = 8'($urandom);
            if (n == 0) int_in = 8'h01;
            a = 8'($urandom);
            @(negedge clk);
            vectors++; if (int_out_n !== !(sysint_m | |int_in[7:1])) begin errors++; $display("FAIL irq_%0d: got %b want %b", n, int_out_n, !(sysint_m | |int_in[7:1])); end
            send(1'b1, 8'd5);
            send(1'b0, a);
            vectors++; if (int_ack !== a) begin errors++; $display("FAIL ack_%0d: got %h want %h", n, int_ack, a); end
            idle(1);
            sysint_m = sysint_m & !a[0];
            send(1'b0, 8'($urandom));
            vectors++; if (bus.data_out !== {int_in[7:1], sysint_m}) begin errors++; $display("FAIL irq_read_%0d: got %h want %h", n, bus.data_out, {int_in[7:1], sysint_m}); end
        end
        int_in = '0;
    endtask
    task automatic test_menu();
        send(1'b1, 8'd8);
        for (int k = 0; k < 17; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(1'b0, 8'($urandom));
            vectors++; if (bus.data_out !== 8'((k % 16) * 29 + 7)) begin errors++; $display("FAIL menu_%0d: got %h want %h", k, bus.data_out, 8'((k % 16) * 29 + 7)); end
        end
        send(1'b1, 8'd8);
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);
        vectors++; if (bus.data_out !== 8'd36) begin errors++; $display("FAIL menu_restart: got %h want 24", bus.data_out); end
    endtask
    task automatic test_unknown();
        send(1'b1, 8'd7);
        for (int k = 0; k < 4; k++) send(1'b0, 8'($urandom));
        vectors++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL unk_data_out: got %h want 00", bus.data_out); end
        vectors++; if (leds !== leds_m) begin errors++; $display("FAIL unk_leds: got %h want %h", leds, leds_m); end
        vectors++; if (color !== color_m) begin errors++; $display("FAIL unk_color: got %h want %h", color, color_m); end
        vectors++; if (cfg_values !== cfg_vec()) begin errors++; $display("FAIL unk_cfg: got %h want %h", cfg_values, cfg_vec()); end
    endtask
    task automatic test_reset_abort();
        send(1'b1, 8'd1);
        do_reset();
        send(1'b0, 8'h03);
        vectors++; if (leds !== 2'b00) begin errors++; $display("FAIL abort_leds: got %h want 0", leds); end
        vectors++; if (cfg_values !== cfg_vec()) begin errors++; $display("FAIL abort_cfg: got %h want %h", cfg_values, cfg_vec()); end
        send(1'b1, 8'd1);
        send(1'b0, 8'h03);
        vectors++; if (leds !== 2'b11) begin errors++; $display("FAIL abort_resume: got %h want 3", leds); end
    endtask
    initial begin
        bus.data_in_strobe = 1'b0;
        bus.data_in_start = 1'b0;
        bus.data_in = '0;
        btn_m = '0;
        test_reset();
        test_timeout();
        test_reset_hold();
        test_cmd0();
        test_status();
        test_leds_color();
        test_cfg();
        test_buttons();
        test_ack_collision();
        test_int_in();
        test_menu();
        test_unknown();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
